// File: rtl/max_seq_ctrl_if.sv
// rtl/max_seq_ctrl_if.sv - handshake bundle for the sequential max controller
//
// Groups every non-clock/reset signal of max_seq_ctrl.
//   start      producer -> block : begin a frame (honoured only when idle)
//   in_valid   producer -> block : in_data carries a sample
//   in_data    producer -> block : WIDTH-bit unsigned sample
//   in_ready   block -> producer : a sample is accepted this cycle if in_valid
//   busy       block -> producer : frame in progress (scanning or holding result)
//   out_valid  block -> consumer : result valid, held until out_ack
//   out_max    block -> consumer : maximum of the frame
//   out_idx    block -> consumer : first index of the maximum
//   out_ack    consumer -> block : result taken
// master is the producer/consumer side, slave is the controller.
interface max_seq_ctrl_if #(
   parameter int WIDTH = 4,
   parameter int IDXW  = 3
);
   logic             start;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             busy;
   logic             out_valid;
   logic [WIDTH-1:0] out_max;
   logic [IDXW-1:0]  out_idx;
   logic             out_ack;

   modport master (
      output start, in_valid, in_data, out_ack,
      input  in_ready, busy, out_valid, out_max, out_idx
   );

   modport slave (
      input  start, in_valid, in_data, out_ack,
      output in_ready, busy, out_valid, out_max, out_idx
   );
endinterface

// File: rtl/max_seq_ctrl.sv
// rtl/max_seq_ctrl.sv - frame maximum finder sharing one comparator over COUNT samples
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  max_seq_ctrl_if.slave handshake bundle (see interface file)
// Parameters: WIDTH sample width, COUNT samples per frame (>= 2),
// IDXW index width (2**IDXW >= COUNT).
// Flow: IDLE --start--> SCAN --COUNT accepts--> DONE --out_ack--> IDLE.
// All outputs are registers or decodes of the state register.
module max_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int COUNT = 8,
   parameter int IDXW  = 3
) (
   input logic          clk,
   input logic          rst,
   max_seq_ctrl_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [IDXW-1:0] LAST = IDXW'(COUNT - 1);

   logic [1:0]       state;
   logic [IDXW-1:0]  cnt;
   logic [WIDTH-1:0] max_r;
   logic [IDXW-1:0]  idx_r;
   logic             take_new;

   // The first sample of a frame always loads, so an all-zero frame still
   // reports index 0; later samples need a strict win, keeping the earliest tie.
   assign take_new = (cnt == '0) || (bus.in_data > max_r);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         max_r <= '0;
         idx_r <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state <= S_SCAN;
                  cnt   <= '0;
                  max_r <= '0;
                  idx_r <= '0;
               end
            end
            S_SCAN: begin
               if (bus.in_valid) begin
                  if (take_new) begin
                     max_r <= bus.in_data;
                     idx_r <= cnt;
                  end
                  if (cnt == LAST) begin
                     state <= S_DONE;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + IDXW'(1);
                  end
               end
            end
            S_DONE: begin
               // start is deliberately ignored here, even alongside out_ack
               if (bus.out_ack) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign bus.in_ready  = (state == S_SCAN);
   assign bus.busy      = (state != S_IDLE);
   assign bus.out_valid = (state == S_DONE);
   assign bus.out_max   = max_r;
   assign bus.out_idx   = idx_r;

endmodule

// File: tb/tb_max_seq_ctrl.sv
// tb/tb_max_seq_ctrl.sv - self-checking bench for max_seq_ctrl
module tb_max_seq_ctrl;

   localparam int WIDTH = 4;
   localparam int COUNT = 8;
   localparam int IDXW  = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   max_seq_ctrl_if #(.WIDTH(WIDTH), .IDXW(IDXW)) bus ();

   max_seq_ctrl #(.WIDTH(WIDTH), .COUNT(COUNT), .IDXW(IDXW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int accepts  = 0;
   int start_cyc = 0;

   // model: phase 0 = waiting for start, 1 = collecting samples, 2 = holding result
   bit m_on    = 1'b0;
   int m_phase = 0;
   int m_q[$];
   int m_max   = 0;
   int m_idx   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Model: after each accept the result is recomputed from the whole frame so far:
   // the largest value, then the lowest position holding that value.
   initial forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_on    = 1'b1;
         m_phase = 0;
         m_q.delete();
         m_max   = 0;
         m_idx   = 0;
      end else if (m_on) begin
         case (m_phase)
            0: if (bus.start) begin
                  m_phase = 1;
                  m_q.delete();
                  m_max = 0;
                  m_idx = 0;
               end
            1: if (bus.in_valid) begin
                  m_q.push_back(int'(bus.in_data));
                  m_max = 0;
                  foreach (m_q[i]) if (m_q[i] > m_max) m_max = m_q[i];
                  m_idx = -1;
                  foreach (m_q[i]) if (m_idx < 0 && m_q[i] == m_max) m_idx = i;
                  if (m_q.size() == COUNT) m_phase = 2;
               end
            default: if (bus.out_ack) m_phase = 0;
         endcase
      end
   end

   // per-cycle comparison against the model, sampled mid-cycle
   initial forever begin
      @(negedge clk);
      if (m_on) begin
         check("in_ready",  bus.in_ready,  32'(m_phase == 1));
         check("busy",      bus.busy,      32'(m_phase != 0));
         check("out_valid", bus.out_valid, 32'(m_phase == 2));
         check("out_max",   bus.out_max,   m_max);
         check("out_idx",   bus.out_idx,   m_idx);
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) accepts++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      bus.start = 1'b1;
      tick();
      start_cyc = cyc;
      bus.start = 1'b0;
   endtask

   // frame: sample i in nibble i counted from the MSB; gaps: idle cycles after sample i
   task automatic feed(input logic [31:0] frame, input logic [31:0] gaps,
                       input bit poke_start, input int n);
      for (int i = 0; i < n; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = frame[31-4*i -: 4];
         tick();
         bus.in_valid = 1'b0;
         bus.in_data  = 4'hF;
         for (int g = 0; g < int'(gaps[31-4*i -: 4]); g++) begin
            bus.start = poke_start;
            tick();
         end
         bus.start = 1'b0;
      end
   endtask

   task automatic ack(input bit with_start);
      bus.out_ack = 1'b1;
      bus.start   = with_start;
      tick();
      bus.out_ack = 1'b0;
      bus.start   = 1'b0;
   endtask

   task automatic expect_result(input string name, input logic [3:0] mx, input logic [2:0] ix);
      check({name, "_valid"}, bus.out_valid, 1);
      check({name, "_max"},   bus.out_max,   mx);
      check({name, "_idx"},   bus.out_idx,   ix);
   endtask

   task automatic expect_cleared(input string name);
      check({name, "_in_ready"},  bus.in_ready,  0);
      check({name, "_busy"},      bus.busy,      0);
      check({name, "_out_valid"}, bus.out_valid, 0);
      check({name, "_out_max"},   bus.out_max,   0);
      check({name, "_out_idx"},   bus.out_idx,   0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end

   initial begin
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.out_ack  = 1'b0;
      rst          = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // idle noise: no start, so nothing may be accepted
      bus.in_valid = 1'b1;
      bus.out_ack  = 1'b1;
      bus.in_data  = 4'hF;
      accepts = 0;
      repeat (4) tick();
      check("idle_accepts", accepts, 0);
      expect_cleared("idle");
      bus.in_valid = 1'b0;
      bus.out_ack  = 1'b0;

      // basic frame with in_valid held high
      accepts = 0;
      do_start();
      check("start_latency_in_ready", bus.in_ready, 1);
      feed(32'h0678_9ABF, 32'h0, 1'b0, 8);
      // the cycle following edge t is numbered t+1
      check("start_to_valid_cycles", (cyc - start_cyc) + 1, 9);
      expect_result("basic", 4'hF, 3'd7);
      check("basic_accepts", accepts, 8);
      repeat (5) begin
         tick();
         check("basic_hold", bus.out_valid, 1);
      end
      ack(1'b0);
      check("basic_ack_drop", bus.out_valid, 0);
      check("basic_max_kept", bus.out_max, 4'hF);

      // ties keep the earliest index
      do_start();
      feed(32'hA3A1_A059, 32'h0, 1'b0, 8);
      expect_result("tie", 4'hA, 3'd0);
      ack(1'b0);

      // all zero
      do_start();
      feed(32'h0000_0000, 32'h0, 1'b0, 8);
      expect_result("zero", 4'h0, 3'd0);
      ack(1'b0);

      // stalled input with start pokes during the gaps
      accepts = 0;
      do_start();
      feed(32'h1C4B_2D08, 32'h0300_0100, 1'b1, 8);
      expect_result("stall", 4'hD, 3'd5);
      check("stall_accepts", accepts, 8);
      ack(1'b0);

      // reset after four samples
      do_start();
      feed(32'hFFFF_0000, 32'h0, 1'b0, 4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      expect_cleared("rst_scan");
      do_start();
      feed(32'h1234_5673, 32'h0, 1'b0, 8);
      expect_result("after_rst", 4'h7, 3'd6);
      ack(1'b0);

      // reset while holding a result
      do_start();
      feed(32'hEEEE_EEEE, 32'h0, 1'b0, 8);
      check("pre_rst_done_valid", bus.out_valid, 1);
      rst = 1'b1;
      bus.out_ack = 1'b1;
      tick();
      rst = 1'b0;
      bus.out_ack = 1'b0;
      expect_cleared("rst_done");
      tick();
      check("rst_done_stays_idle", bus.out_valid, 0);
      do_start();
      feed(32'h3141_5926, 32'h0, 1'b0, 8);
      expect_result("pi", 4'h9, 3'd5);

      // ack together with start: returns to idle without starting
      ack(1'b1);
      check("b2b_busy", bus.busy, 0);
      check("b2b_in_ready", bus.in_ready, 0);
      check("b2b_valid", bus.out_valid, 0);
      check("b2b_idx_kept", bus.out_idx, 3'd5);
      do_start();
      check("b2b_start_in_ready", bus.in_ready, 1);
      feed(32'h9000_0000, 32'h0, 1'b0, 8);
      expect_result("second", 4'h9, 3'd0);
      ack(1'b0);
      repeat (3) tick();
      check("idle_max_kept", bus.out_max, 4'h9);
      check("idle_idx_kept", bus.out_idx, 3'd0);
      check("idle_busy", bus.busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/max_seq_ctrl.md
# max_seq_ctrl

Sequential controller that time-shares one WIDTH-bit max comparator across a frame of COUNT input samples. It accepts samples over a valid/ready handshake and tracks the running maximum and the index of its first occurrence. It then presents the result under a hold-until-acknowledged handshake. It sits in front of the 4-bit max datapath and replaces COUNT-1 parallel comparators with one comparator plus a small FSM.

## Interface
- WIDTH, 4, sample and result width in bits
- COUNT, 8, samples per frame; must be at least 2
- IDXW, 3, index width; must satisfy 2**IDXW >= COUNT
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a frame; honoured only in IDLE
- in_valid  input  1  in_data holds a sample
- in_data  input  WIDTH  sample value, unsigned
- in_ready  output  1  block accepts a sample this cycle
- busy  output  1  frame in progress (SCAN or DONE)
- out_valid  output  1  result valid; held until acknowledged
- out_max  output  WIDTH  maximum of the frame, unsigned
- out_idx  output  IDXW  position in the frame (0-based) of the first sample equal to out_max
- out_ack  input  1  consumer takes the result

Clock and reset: one clock; reset is synchronous and active-high.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=0, busy=0, out_valid=0.
  - start=1 → SCAN. The same edge clears the sample counter, out_max and out_idx to 0.
- SCAN:
  - in_ready=1, busy=1.
  - A sample is accepted on every cycle with in_valid=1. No sample is accepted when in_valid=0, and the state is held with no timeout.
  - Counter n (0..COUNT-1) is the index of the sample being accepted.
  - n==0: out_max←in_data, out_idx←0. This is unconditional, so a frame of all zeros still reports index 0.
  - n>0: if in_data > out_max (strict, unsigned), then out_max←in_data and out_idx←n. Otherwise both hold. On a tie the earliest index is kept.
  - The accept with n==COUNT-1 → DONE. The counter does not wrap into a new frame.
- DONE:
  - out_valid=1, in_ready=0, busy=1. out_max and out_idx are frozen.
  - out_ack=1 → IDLE.
- start is ignored outside IDLE, including when start and out_ack are both high in DONE. A new frame needs start in IDLE.
- out_max and out_idx hold their last result after returning to IDLE until the next start.
- in_data is ignored whenever in_ready=0.
- Comparison is a pure WIDTH-bit unsigned compare with no sign extension. The counter is IDXW bits wide and never exceeds COUNT-1.

## Timing
- Reset (rst=1 at an edge, in any state, including mid-SCAN or in DONE):
  - state=IDLE, counter=0, in_ready=0, busy=0, out_valid=0, out_max=0, out_idx=0.
  - Partial frames are discarded; no out_valid is produced for them.
  - rst takes priority over start, in_valid and out_ack in the same cycle.
- Start latency: start sampled at edge t → in_ready=1 from cycle t+1.
- Result latency: the last sample accepted at edge t → out_valid=1 in cycle t+1, with final out_max and out_idx.
- Minimum frame time, start edge to out_valid: COUNT+1 cycles, when in_valid is held high.
- out_ack is sampled only when out_valid=1; out_ack in IDLE or SCAN has no effect.
- out_ack at edge t in DONE → out_valid=0 and IDLE in cycle t+1. The earliest next start is sampled at edge t+1, so back-to-back frames have a 1-cycle IDLE gap.
- All outputs are registered or decoded from registered state; there is no combinational path from an input to an output.

## Test plan
- Reset values and idle behaviour:
  - Assert rst for 2 cycles, then drive in_valid=1 and out_ack=1 without start.
  - Required: all outputs stay 0 and no sample is accepted.
- Basic frame, COUNT=8:
  - start, then in_valid held high with samples 0000,0110,0111,1000,1001,1010,1011,1111.
  - Required: out_valid rises exactly 9 cycles after the start edge, with out_max=1111 and out_idx=7.
  - out_valid stays high for 5 cycles with no out_ack, then drops 1 cycle after out_ack.
- Tie and first-sample maximum:
  - Samples 1010,0011,1010,0001,1010,0000,0101,1001 → out_max=1010, out_idx=0.
  - All-zero frame → out_max=0000, out_idx=0.
- Stalled input:
  - Samples 0001,1100,0100,1011,0010,1101,0000,1000, with in_valid low for 3 cycles after the 2nd sample and 1 cycle after the 6th.
  - Required: in_ready stays high throughout SCAN, exactly 8 accepts occur, and out_max=1101, out_idx=5.
  - start pulses during SCAN are ignored.
- Reset mid-operation:
  - rst after 4 accepted samples → all outputs 0 the next cycle.
  - A following fresh 8-sample frame reports only its own samples.
  - Repeat with rst asserted while in DONE.
- Back-to-back frames:
  - out_ack and start both high in DONE → IDLE, and no new frame starts.
  - start on the next cycle → in_ready rises 1 cycle later.
  - Second frame 1001,0000,...,0000 → out_max=1001, out_idx=0; out_max holds its value across IDLE.
